spi_slave_axis_egress_framed: RTL and testbench



---
 rtl/spi_egress_pkg.sv | 11 +
 rtl/spi_egress_fifo.sv | 33 +++
 rtl/spi_slave_axis_egress_framed.sv | 71 +++++++
 tb/tb_spi_slave_axis_egress_framed.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/spi_egress_pkg.sv
// spi_egress_pkg: shared framing state, byte-step helper and parameter legality check for the SPI egress path
package spi_egress_pkg;
  typedef enum logic [1:0] {SYNC, HEADER, DATA} state_t;
  function automatic int steps_per_byte(input int miso_size);
    return 8 / miso_size;
  endfunction
  function automatic bit params_ok(input int miso_size, input int mtu_size);
    return (miso_size inside {1, 2, 4, 8}) && mtu_size >= 2 && mtu_size <= 128 &&
           (mtu_size & (mtu_size - 1)) == 0;
  endfunction
endpackage

// File: rtl/spi_egress_fifo.sv
// spi_egress_fifo: byte FIFO with first-word-fall-through head, power-of-2 depth
module spi_egress_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [7:0]               din_i,
  output logic [7:0]               head_o,
  output logic [$clog2(DEPTH):0]   fill_o,
  output logic                     full_o
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0] fill_q;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      rd_q <= '0;
      wr_q <= '0;
      fill_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + AW'(1);
      if (pop_i) rd_q <= rd_q + AW'(1);
      fill_q <= fill_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
  always_ff @(posedge clk_i)
    if (push_i) mem_q[wr_q] <= din_i;
  assign head_o = mem_q[rd_q];
  assign fill_o = fill_q;
  assign full_o = fill_q == (AW+1)'(DEPTH);
endmodule

// File: rtl/spi_slave_axis_egress_framed.sv
// spi_slave_axis_egress_framed: AXI-Stream bytes framed as header + MTU_SIZE padded slots, shifted out on MISO lanes
module spi_slave_axis_egress_framed
  import spi_egress_pkg::*;
#(
  parameter int         MISO_SIZE = 1,
  parameter bit         MSB_FIRST = 1'b1,
  parameter int         MTU_SIZE  = 16,
  parameter logic [7:0] SYNC_BYTE = 8'h00
) (
  input  logic                        spi_clk,
  input  logic                        res,
  output logic [MISO_SIZE-1:0]        spi_miso,
  input  logic [7:0]                  s_axis_tdata,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  input  logic [7:0]                  s_axis_tuser,
  output logic                        frame_start,
  output logic [$clog2(MTU_SIZE):0]   fifo_fill
);
  localparam int S  = steps_per_byte(MISO_SIZE);
  localparam int CW = (S > 1) ? $clog2(S) : 1;
  localparam int SW = $clog2(MTU_SIZE);
  localparam int FW = SW + 1;
  if (!params_ok(MISO_SIZE, MTU_SIZE)) begin : g_bad_params
    $error("spi_slave_axis_egress_framed: illegal MISO_SIZE or MTU_SIZE");
  end
  state_t state_q, state_d;
  logic [7:0] sh_q, sh_d, head;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] slot_q, slot_d;
  logic [FW-1:0] pend_q, pend_d, fill;
  logic fs_q, fs_d, full, load, load_hdr, push, pop;
  spi_egress_fifo #(.DEPTH(MTU_SIZE)) u_fifo (
    .clk_i(spi_clk), .rst_i(res), .push_i(push), .pop_i(pop), .din_i(s_axis_tdata),
    .head_o(head), .fill_o(fill), .full_o(full)
  );
  assign load = cnt_q == CW'(S - 1);
  // a header follows SYNC and the last payload slot; every other load is a payload slot
  assign load_hdr = load && (state_q == SYNC || (state_q == DATA && slot_q == SW'(MTU_SIZE - 1)));
  assign pop = load && !load_hdr && pend_q != '0;
  assign s_axis_tready = !res && !full;
  assign push = s_axis_tvalid && s_axis_tready;
  assign fifo_fill = fill;
  assign frame_start = fs_q;
  assign spi_miso = MSB_FIRST ? sh_q[7 -: MISO_SIZE] : sh_q[MISO_SIZE-1:0];
  always_comb begin
    cnt_d = load ? '0 : cnt_q + CW'(1);
    pend_d = load_hdr ? fill : pop ? pend_q - FW'(1) : pend_q;
    sh_d = !load ? (MSB_FIRST ? sh_q << MISO_SIZE : sh_q >> MISO_SIZE) :
           load_hdr ? 8'(fill) : pop ? head : s_axis_tuser;
    state_d = !load ? state_q : load_hdr ? HEADER : DATA;
    slot_d = !load ? slot_q : state_q == DATA ? slot_q + SW'(1) : '0;
    fs_d = load ? load_hdr : fs_q;
  end
  always_ff @(posedge spi_clk or posedge res)
    if (res) begin
      sh_q <= SYNC_BYTE;
      cnt_q <= '0;
      state_q <= SYNC;
      slot_q <= '0;
      pend_q <= '0;
      fs_q <= 1'b0;
    end else begin
      sh_q <= sh_d;
      cnt_q <= cnt_d;
      state_q <= state_d;
      slot_q <= slot_d;
      pend_q <= pend_d;
      fs_q <= fs_d;
    end
endmodule

// File: tb/tb_spi_slave_axis_egress_framed.sv
// tb_spi_slave_axis_egress_framed: two configurations checked every cycle against a byte-stream reference model
module tb_spi_slave_axis_egress_framed;
  localparam int MTU = 4;
  localparam logic [7:0] SYNC1 = 8'h3C;
  logic clk = 1'b0;
  logic res = 1'b1;
  logic [7:0] tdata [2];
  logic tvalid [2];
  logic tready [2];
  logic [7:0] tuser = 8'hA5;
  logic [0:0] miso0;
  logic [1:0] miso1;
  logic fs [2];
  logic [2:0] fill [2];
  int checks = 0, failures = 0;
  logic [7:0] acc_log [2][1024];
  int wr [2], rd [2], t [2], pend [2], sidx [2];
  logic [7:0] cur [2];
  logic acc [2];
  logic [7:0] src [8];
  int nsrc = 0;
  always #5 clk = ~clk;
  spi_slave_axis_egress_framed #(.MISO_SIZE(1), .MSB_FIRST(1'b1), .MTU_SIZE(MTU), .SYNC_BYTE(8'h00)) dut0 (
    .spi_clk(clk), .res(res), .spi_miso(miso0), .s_axis_tdata(tdata[0]), .s_axis_tvalid(tvalid[0]),
    .s_axis_tready(tready[0]), .s_axis_tuser(tuser), .frame_start(fs[0]), .fifo_fill(fill[0]));
  spi_slave_axis_egress_framed #(.MISO_SIZE(2), .MSB_FIRST(1'b0), .MTU_SIZE(MTU), .SYNC_BYTE(SYNC1)) dut1 (
    .spi_clk(clk), .res(res), .spi_miso(miso1), .s_axis_tdata(tdata[1]), .s_axis_tvalid(tvalid[1]),
    .s_axis_tready(tready[1]), .s_axis_tuser(tuser), .frame_start(fs[1]), .fifo_fill(fill[1]));
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @%0t: got %0h want %0h", tag, $time, act, exp);
    end
  endtask
  function automatic int spb(input int k);
    return k == 0 ? 8 : 4;
  endfunction
  function automatic bit is_hdr(input int bi);
    return bi >= 1 && (bi - 1) % (MTU + 1) == 0;
  endfunction
  // instance 0 sends bit 7 first one lane at a time, instance 1 sends bit 0 first two lanes at a time
  function automatic logic [7:0] lane(input int k, input logic [7:0] b, input int p);
    int m, sft;
    m = k == 0 ? 1 : 2;
    sft = k == 0 ? 8 - m * (p + 1) : m * p;
    return 8'((32'(b) >> sft) & ((1 << m) - 1));
  endfunction
  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      t[k] = 0; pend[k] = 0; rd[k] = wr[k]; sidx[k] = 0; tvalid[k] = 1'b0; tdata[k] = 8'h00;
      cur[k] = k == 0 ? 8'h00 : SYNC1;
    end
  endtask
  task automatic model_edge(input int k);
    int s, b, f;
    s = spb(k);
    if (t[k] % s == s - 1) begin
      b = t[k] / s + 1;
      f = wr[k] - rd[k];
      if (is_hdr(b)) begin
        pend[k] = f < MTU ? f : MTU;
        cur[k] = 8'(pend[k]);
      end else if (pend[k] > 0) begin
        cur[k] = acc_log[k][rd[k] % 1024];
        rd[k]++;
        pend[k]--;
      end else cur[k] = tuser;
    end
    if (acc[k]) begin
      acc_log[k][wr[k] % 1024] = tdata[k];
      wr[k]++;
      sidx[k]++;
    end
    t[k]++;
  endtask
  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      int s;
      logic [7:0] m_act;
      s = spb(k);
      m_act = k == 0 ? 8'(miso0) : 8'(miso1);
      chk($sformatf("miso%0d", k), 32'(m_act), 32'(lane(k, cur[k], t[k] % s)));
      chk($sformatf("fill%0d", k), 32'(fill[k]), 32'(wr[k] - rd[k]));
      chk($sformatf("tready%0d", k), 32'(tready[k]), 32'(!res && (wr[k] - rd[k]) < MTU));
      chk($sformatf("frame_start%0d", k), 32'(fs[k]), 32'(is_hdr(t[k] / s)));
    end
  endtask
  // mode 0 idle, 1 push src list, 2 random with hold-until-accepted, 3 continuous push
  task automatic drive(input int mode);
    for (int k = 0; k < 2; k++)
      case (mode)
        1: begin
          tvalid[k] = sidx[k] < nsrc;
          tdata[k] = sidx[k] < nsrc ? src[sidx[k]] : 8'h00;
        end
        2: if (!(tvalid[k] && !acc[k])) begin
          tvalid[k] = 1'($urandom_range(0, 1));
          tdata[k] = 8'($urandom);
        end
        3: begin
          tvalid[k] = 1'b1;
          tdata[k] = 8'(8'h40 + sidx[k]);
        end
        default: tvalid[k] = 1'b0;
      endcase
    if (mode == 2) tuser = 8'($urandom);
  endtask
  task automatic step(input int mode);
    drive(mode);
    for (int k = 0; k < 2; k++) acc[k] = tvalid[k] && !res && (wr[k] - rd[k]) < MTU;
    @(posedge clk);
    if (!res) for (int k = 0; k < 2; k++) model_edge(k);
    @(negedge clk);
    check_all();
  endtask
  task automatic apply_reset(input int n);
    res = 1'b1;
    model_reset();
    for (int k = 0; k < 2; k++) acc[k] = 1'b0;
    #1 check_all();
    repeat (n) step(0);
    res = 1'b0;
  endtask
  initial begin
    for (int k = 0; k < 2; k++) begin wr[k] = 0; acc[k] = 1'b0; end
    model_reset();
    @(negedge clk);
    apply_reset(2);
    tuser = 8'hA5;
    repeat (100) step(0);
    apply_reset(1);
    src[0] = 8'h11; src[1] = 8'h22; src[2] = 8'h33; nsrc = 3;
    repeat (60) step(1);
    apply_reset(1);
    for (int i = 0; i < 6; i++) src[i] = 8'(i + 1);
    nsrc = 6;
    repeat (100) step(1);
    apply_reset(1);
    repeat (5) step(3);
    chk("full_tready0", 32'(tready[0]), 32'd0);
    chk("full_fill0", 32'(fill[0]), 32'd4);
    repeat (115) step(3);
    apply_reset(1);
    src[0] = 8'hB4; nsrc = 1;
    repeat (60) step(1);
    apply_reset(1);
    for (int i = 0; i < 4; i++) src[i] = 8'(8'h90 + i);
    nsrc = 4;
    repeat (20) step(1);
    chk("fill_pre_rst0", 32'(fill[0]), 32'd3);
    apply_reset(1);
    chk("fill_post_rst0", 32'(fill[0]), 32'd0);
    src[0] = 8'h77; nsrc = 1;
    repeat (60) step(1);
    apply_reset(1);
    repeat (2000) step(2);
    apply_reset(1);
    repeat (40) step(0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
